// File: rtl/ibex_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ibex_mem_port_arbiter
// Purpose  : Shares one req/gnt/rvalid bus between fetch and load/store ports.
// Revision : 1.0
// ============================================================================
module ibex_mem_port_arbiter #(
    parameter int MaxOutstanding = 2,
    parameter int StarveLimit    = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i,
    output logic [3:0]  outstanding_o,
    output logic        protocol_err_o
);

    localparam int              PtrW      = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [PtrW-1:0] LastPtr   = PtrW'(MaxOutstanding - 1);
    localparam logic [3:0]      MaxCnt    = 4'(MaxOutstanding);
    localparam logic [3:0]      StarveMax = 4'(StarveLimit);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [MaxOutstanding-1:0] fifo_q;
    logic [PtrW-1:0]           wptr_q, rptr_q;
    logic [3:0]                count_q, count_d;
    logic [3:0]                starve_q, starve_d;
    logic                      perr_q, perr_d;

    logic sel_data, sel_req, push, pop, head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign head = fifo_q[rptr_q];
    assign pop  = bus_rvalid_i & (count_q != 4'd0);

    always_comb begin
        state_d     = IDLE;
        sel_data    = 1'b0;
        bus_we_o    = 1'b0;
        bus_be_o    = 4'h0;
        bus_addr_o  = 32'h0;
        bus_wdata_o = 32'h0;

        case (state_q)
            IDLE:    sel_data = data_req_i &
                                ~(instr_req_i & (starve_q == StarveMax));
            HOLD_D:  sel_data = 1'b1;
            default: sel_data = 1'b0;
        endcase

        sel_req = sel_data ? data_req_i : instr_req_i;
        // Full blocks the request purely on the registered count.
        bus_req_o   = sel_req & (count_q < MaxCnt);
        push        = bus_req_o & bus_gnt_i;
        instr_gnt_o = push & ~sel_data;
        data_gnt_o  = push & sel_data;

        if (sel_req) begin
            if (sel_data) begin
                bus_we_o    = data_we_i;
                bus_be_o    = data_be_i;
                bus_addr_o  = data_addr_i;
                bus_wdata_o = data_wdata_i;
            end else begin
                bus_be_o    = 4'hF;
                bus_addr_o  = instr_addr_i;
            end
        end

        if (sel_req & ~push) begin
            state_d = sel_data ? HOLD_D : HOLD_I;
        end

        count_d = count_q;
        if (push & ~pop) begin
            count_d = count_q + 4'd1;
        end else if (~push & pop) begin
            count_d = count_q - 4'd1;
        end

        starve_d = starve_q;
        if (~instr_req_i | instr_gnt_o) begin
            starve_d = 4'd0;
        end else if (data_gnt_o & (starve_q != StarveMax)) begin
            starve_d = starve_q + 4'd1;
        end

        perr_d = perr_q | (bus_rvalid_i & (count_q == 4'd0));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            fifo_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= 4'd0;
            starve_q <= 4'd0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            perr_q   <= perr_d;
            if (push) begin
                fifo_q[wptr_q] <= sel_data;
                wptr_q         <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
        end
    end

    assign instr_rvalid_o = pop & ~head;
    assign data_rvalid_o  = pop & head;
    assign instr_rdata_o  = instr_rvalid_o ? bus_rdata_i : 32'h0;
    assign data_rdata_o   = data_rvalid_o  ? bus_rdata_i : 32'h0;
    assign instr_err_o    = instr_rvalid_o & bus_err_i;
    assign data_err_o     = data_rvalid_o  & bus_err_i;
    assign outstanding_o  = count_q;
    assign protocol_err_o = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_ibex_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_mem_port_arbiter
// Purpose  : Directed self-checking bench with an in-order response scoreboard.
// Revision : 1.0
// ============================================================================
module tb_ibex_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = 32'h0;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_addr_i = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic        bus_gnt_i = 1'b0;
    logic        bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = 32'h0;
    logic        bus_err_i = 1'b0;
    logic [3:0]  outstanding_o;
    logic        protocol_err_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic cur_v = 1'b0;

    ibex_mem_port_arbiter #(.MaxOutstanding(2), .StarveLimit(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
        .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        bus_rvalid_i = 1'b0;
        bus_err_i    = 1'b0;
        cur_v        = 1'b0;
    endtask

    task automatic push_exp(input logic port, input logic [31:0] data, input logic err);
        exp_t e;
        e.port = port;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic drive_resp();
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed=0 expected=nonzero");
        end else begin
            cur          = sb.pop_front();
            cur_v        = 1'b1;
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = cur.data;
            bus_err_i    = cur.err;
        end
    endtask

    task automatic check_resp();
        if (cur_v) begin
            chk("instr_rvalid", {31'b0, instr_rvalid_o}, {31'b0, ~cur.port});
            chk("data_rvalid",  {31'b0, data_rvalid_o},  {31'b0, cur.port});
            if (cur.port) begin
                chk("data_rdata", data_rdata_o, cur.data);
                chk("data_err", {31'b0, data_err_o}, {31'b0, cur.err});
            end else begin
                chk("instr_rdata", instr_rdata_o, cur.data);
                chk("instr_err", {31'b0, instr_err_o}, {31'b0, cur.err});
            end
        end else begin
            chk("instr_rvalid_idle", {31'b0, instr_rvalid_o}, 32'h0);
            chk("data_rvalid_idle",  {31'b0, data_rvalid_o},  32'h0);
        end
    endtask

    task automatic check_gnt(input logic exp_i, input logic exp_d);
        chk("instr_gnt", {31'b0, instr_gnt_o}, {31'b0, exp_i});
        chk("data_gnt",  {31'b0, data_gnt_o},  {31'b0, exp_d});
    endtask

    initial begin
        // Reset
        tick();
        tick();
        chk("rst_outstanding", {28'b0, outstanding_o}, 32'h0);
        chk("rst_perr", {31'b0, protocol_err_o}, 32'h0);
        chk("rst_bus_req", {31'b0, bus_req_o}, 32'h0);
        chk("rst_bus_addr", bus_addr_o, 32'h0);
        check_gnt(1'b0, 1'b0);
        rst_ni = 1'b1;
        tick();

        // Instruction-only fetches, grant held high
        bus_gnt_i = 1'b1;
        instr_req_i = 1'b1; instr_addr_i = 32'h100;
        #1;
        chk("t1_bus_req", {31'b0, bus_req_o}, 32'h1);
        chk("t1_addr0", bus_addr_o, 32'h100);
        chk("t1_be", {28'b0, bus_be_o}, 32'hF);
        chk("t1_we", {31'b0, bus_we_o}, 32'h0);
        chk("t1_wdata", bus_wdata_o, 32'h0);
        check_gnt(1'b1, 1'b0);
        push_exp(1'b0, 32'hDEADBEEF, 1'b0);
        tick();
        instr_addr_i = 32'h104;
        drive_resp();
        #1;
        chk("t1_addr1", bus_addr_o, 32'h104);
        chk("t1_out1", {28'b0, outstanding_o}, 32'h1);
        check_gnt(1'b1, 1'b0);
        check_resp();
        push_exp(1'b0, 32'h12345678, 1'b0);
        tick();
        instr_req_i = 1'b0;
        drive_resp();
        #1;
        check_resp();
        tick();
        #1;
        chk("t1_out_end", {28'b0, outstanding_o}, 32'h0);
        check_resp();

        // Simultaneous requests: data first, then instruction, in-order responses
        instr_req_i = 1'b1; instr_addr_i = 32'h300;
        data_req_i = 1'b1; data_addr_i = 32'h2000; data_we_i = 1'b1;
        data_be_i = 4'b0011; data_wdata_i = 32'hA5A5;
        #1;
        check_gnt(1'b0, 1'b1);
        chk("t2_addr", bus_addr_o, 32'h2000);
        chk("t2_we", {31'b0, bus_we_o}, 32'h1);
        chk("t2_be", {28'b0, bus_be_o}, 32'h3);
        chk("t2_wdata", bus_wdata_o, 32'hA5A5);
        chk("t2_out0", {28'b0, outstanding_o}, 32'h0);
        push_exp(1'b1, 32'h11111111, 1'b1);
        tick();
        data_req_i = 1'b0;
        #1;
        check_gnt(1'b1, 1'b0);
        chk("t2_addr_i", bus_addr_o, 32'h300);
        chk("t2_out1", {28'b0, outstanding_o}, 32'h1);
        push_exp(1'b0, 32'h22222222, 1'b0);
        tick();
        instr_req_i = 1'b0; data_we_i = 1'b0;
        drive_resp();
        #1;
        chk("t2_out2", {28'b0, outstanding_o}, 32'h2);
        check_resp();
        tick();
        drive_resp();
        #1;
        chk("t2_out3", {28'b0, outstanding_o}, 32'h1);
        check_resp();
        tick();
        #1;
        chk("t2_out4", {28'b0, outstanding_o}, 32'h0);

        // Starvation: four data grants, then one instruction grant, repeating
        instr_req_i = 1'b1; instr_addr_i = 32'h8000;
        data_req_i = 1'b1; data_be_i = 4'hF;
        for (int i = 0; i < 10; i++) begin
            data_addr_i = 32'h4000 + 32'(i * 4);
            if (i > 0) drive_resp();
            #1;
            check_resp();
            check_gnt((i % 5) == 4, (i % 5) != 4);
            push_exp((i % 5) != 4, 32'hC0DE0000 + 32'(i), 1'b0);
            tick();
        end
        instr_req_i = 1'b0; data_req_i = 1'b0;
        drive_resp();
        #1;
        check_resp();
        tick();
        #1;
        chk("t3_out_end", {28'b0, outstanding_o}, 32'h0);

        // Hold: instruction held while ungranted, data arrives mid-hold
        bus_gnt_i = 1'b0;
        instr_req_i = 1'b1; instr_addr_i = 32'h500;
        data_addr_i = 32'h600;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) data_req_i = 1'b1;
            #1;
            chk("t4_hold_addr", bus_addr_o, 32'h500);
            check_gnt(1'b0, 1'b0);
            tick();
        end
        bus_gnt_i = 1'b1;
        #1;
        chk("t4_gnt_addr", bus_addr_o, 32'h500);
        check_gnt(1'b1, 1'b0);
        push_exp(1'b0, 32'hAAAA0001, 1'b0);
        tick();
        instr_req_i = 1'b0;
        #1;
        chk("t4_data_addr", bus_addr_o, 32'h600);
        check_gnt(1'b0, 1'b1);
        push_exp(1'b1, 32'hAAAA0002, 1'b0);
        tick();
        data_req_i = 1'b0;
        drive_resp();
        #1;
        check_resp();
        tick();
        drive_resp();
        #1;
        check_resp();
        tick();

        // Full: two outstanding block the bus request until a response
        data_req_i = 1'b1; data_addr_i = 32'h700;
        #1;
        check_gnt(1'b0, 1'b1);
        push_exp(1'b1, 32'hBBBB0001, 1'b0);
        tick();
        #1;
        check_gnt(1'b0, 1'b1);
        push_exp(1'b1, 32'hBBBB0002, 1'b0);
        tick();
        drive_resp();
        #1;
        chk("t5_full_out", {28'b0, outstanding_o}, 32'h2);
        chk("t5_full_req", {31'b0, bus_req_o}, 32'h0);
        check_gnt(1'b0, 1'b0);
        check_resp();
        tick();
        #1;
        chk("t5_req_back", {31'b0, bus_req_o}, 32'h1);
        check_gnt(1'b0, 1'b1);
        push_exp(1'b1, 32'hBBBB0003, 1'b0);
        tick();
        data_req_i = 1'b0;
        drive_resp();
        #1;
        chk("t5_out2", {28'b0, outstanding_o}, 32'h2);
        check_resp();
        tick();
        drive_resp();
        #1;
        check_resp();
        tick();
        #1;
        chk("t5_out_end", {28'b0, outstanding_o}, 32'h0);

        // Protocol error on stray response, then reset with work in flight
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFF0000;
        #1;
        check_resp();
        chk("t6_perr_pre", {31'b0, protocol_err_o}, 32'h0);
        tick();
        #1;
        chk("t6_perr_set", {31'b0, protocol_err_o}, 32'h1);
        chk("t6_out0", {28'b0, outstanding_o}, 32'h0);
        instr_req_i = 1'b1; instr_addr_i = 32'h900;
        tick();
        tick();
        instr_req_i = 1'b0;
        #1;
        chk("t6_perr_sticky", {31'b0, protocol_err_o}, 32'h1);
        chk("t6_out2", {28'b0, outstanding_o}, 32'h2);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_out", {28'b0, outstanding_o}, 32'h0);
        chk("t6_rst_perr", {31'b0, protocol_err_o}, 32'h0);
        sb.delete();
        tick();
        rst_ni = 1'b1;
        #1;
        chk("t6_idle_req", {31'b0, bus_req_o}, 32'h0);
        check_gnt(1'b0, 1'b0);
        bus_rvalid_i = 1'b1;
        #1;
        check_resp();
        tick();
        #1;
        chk("t6_perr_after", {31'b0, protocol_err_o}, 32'h1);
        chk("t6_out_after", {28'b0, outstanding_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ibex_mem_port_arbiter.md
Name: ibex_mem_port_arbiter

Overview:
- Shares one external memory bus between the core's instruction-fetch port and its load/store port, using the same req/gnt/rvalid protocol on all three sides.
- Arbitrates new requests and holds the winner stable until it is granted.
- Tracks the issuing port of every outstanding transaction in order, and routes each response back to that port.
- Sits between the core's memory ports and a single-port SoC memory or interconnect.

Parameters:
- MaxOutstanding, 2: maximum accepted-but-unanswered bus transactions, range 1..8.
- StarveLimit, 4: consecutive data grants allowed while instruction request is pending before instruction gets forced priority, range 1..15.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch address
- instr_gnt_o  out  1  fetch request accepted
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch response data
- instr_err_o  out  1  fetch response error
- data_req_i  in  1  load/store request
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  32  load/store address
- data_wdata_i  in  32  store data
- data_gnt_o  out  1  load/store accepted
- data_rvalid_o  out  1  load/store response valid
- data_rdata_o  out  32  load data
- data_err_o  out  1  load/store error
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write enable (0 for fetches)
- bus_be_o  out  4  bus byte enables (4'hF for fetches)
- bus_addr_o  out  32  bus address
- bus_wdata_o  out  32  bus write data (0 for fetches)
- bus_gnt_i  in  1  bus grant
- bus_rvalid_i  in  1  bus response valid
- bus_rdata_i  in  32  bus response data
- bus_err_i  in  1  bus response error
- outstanding_o  out  4  current outstanding count
- protocol_err_o  out  1  sticky: rvalid received with nothing outstanding

Behaviour:
- Reset: FSM returns to IDLE, outstanding FIFO is emptied, and the starvation counter and protocol_err_o clear.
  - outstanding_o resets to 0.
  - With requests low, every output is 0.
  - Reset mid-transaction drops all tracking; responses that arrive after reset are handled by the empty-FIFO rule.
- FSM states:
  - IDLE: no request is being held.
  - HOLD_I: an instruction request is presented and not yet granted.
  - HOLD_D: a data request is presented and not yet granted.
- IDLE selection:
  - Data wins by default.
  - Instruction wins if data_req_i is low, or if the starvation counter equals StarveLimit and instr_req_i is high.
  - Selection is combinational in the same cycle: zero-cycle request latency.
- Holding rules:
  - If the selected request is not granted, the FSM moves to HOLD_I or HOLD_D.
  - In a hold state the same port stays selected regardless of the other port, until bus_gnt_i.
  - After the grant the FSM returns to IDLE. A back-to-back grant is allowed when the next request is also granted in that IDLE cycle.
- Bus drive: bus_req_o = selected port's req AND (count < MaxOutstanding). Bus address/we/be/wdata are muxed from the selected port.
- Grant: the selected port's gnt_o = bus_gnt_i AND bus_req_o. The other port's gnt_o = 0.
- Full condition:
  - When count == MaxOutstanding, bus_req_o = 0 even if bus_rvalid_i pops in the same cycle. There is no combinational path from rvalid to req.
  - A held request stays held while full.
- Outstanding FIFO:
  - Depth MaxOutstanding, 1-bit entries (0 = instr, 1 = data).
  - Push on bus_req_o & bus_gnt_i; pop on bus_rvalid_i.
  - Simultaneous push and pop keeps the count unchanged; order is preserved.
  - Pointers wrap modulo MaxOutstanding.
- Response routing:
  - Combinational from bus_rvalid_i and the FIFO head.
  - The head's port gets rvalid_o = 1, rdata_o = bus_rdata_i, err_o = bus_err_i.
  - The other port's rvalid_o = 0; both rdata_o outputs may carry bus_rdata_i.
  - Responses return in the same cycle as bus_rvalid_i.
- Empty FIFO: bus_rvalid_i with count 0 asserts no port rvalid, does not change the count, and sets protocol_err_o until reset.
- Starvation counter:
  - Increments on each data grant while instr_req_i = 1, saturating at StarveLimit.
  - Clears on each instruction grant, or whenever instr_req_i = 0.

Test Plan:
- Instr only, bus_gnt_i = 1 permanently, addresses 0x100, 0x104 → bus_addr_o follows in the same cycle, bus_be_o = 4'hF, bus_we_o = 0.
  - With rvalid one cycle later and rdata 0xDEADBEEF, 0x12345678: instr_rvalid_o pulses with those values; data_rvalid_o stays 0.
- Both ports request at the same cycle with gnt → data (addr 0x2000, we = 1, be = 4'b0011, wdata 0xA5A5) is granted first.
  - Instruction is granted next cycle.
  - Responses return in order (data, then instr); outstanding_o goes 0→1→2→1→0.
- Data and instr both continuously requesting, StarveLimit = 4 → exactly 4 data grants, then 1 instr grant, then the pattern repeats.
- Instr request with bus_gnt_i held 0 for 3 cycles while data_req_i rises in cycle 2 → bus_addr_o stays on the instr address until the grant; data is granted afterwards.
- MaxOutstanding = 2 and two grants with no rvalid → bus_req_o = 0 with a request pending.
  - An rvalid cycle drops the count to 1; bus_req_o reasserts the next cycle.
- bus_rvalid_i with count 0 → protocol_err_o = 1 and stays set.
  - Assert rst_ni = 0 with 2 outstanding → outstanding_o = 0, protocol_err_o = 0, state IDLE.
